// File: rtl/stack_pkg.sv
// Op codes and per-op stack requirement table for the stack engine.
package stack_pkg;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_PUSH  = 4'd1;
   localparam logic [3:0] OP_POP   = 4'd2;
   localparam logic [3:0] OP_DUP   = 4'd3;
   localparam logic [3:0] OP_SWAP  = 4'd4;
   localparam logic [3:0] OP_OVER  = 4'd5;
   localparam logic [3:0] OP_ROT   = 4'd6;
   localparam logic [3:0] OP_ADD   = 4'd7;
   localparam logic [3:0] OP_SUB   = 4'd8;
   localparam logic [3:0] OP_RPUSH = 4'd9;
   localparam logic [3:0] OP_RPOP  = 4'd10;
   localparam logic [3:0] OP_TOR   = 4'd11;
   localparam logic [3:0] OP_FROMR = 4'd12;

   // d_need/r_need: entries consumed; d_grow/r_grow: op has net growth on that stack
   typedef struct packed {
      logic [1:0] d_need;
      logic       r_need;
      logic       d_grow;
      logic       r_grow;
   } op_req_t;

   localparam op_req_t OP_REQ [16] = '{
      '{2'd0, 1'b0, 1'b0, 1'b0},  // NOP
      '{2'd0, 1'b0, 1'b1, 1'b0},  // PUSH
      '{2'd1, 1'b0, 1'b0, 1'b0},  // POP
      '{2'd1, 1'b0, 1'b1, 1'b0},  // DUP
      '{2'd2, 1'b0, 1'b0, 1'b0},  // SWAP
      '{2'd2, 1'b0, 1'b1, 1'b0},  // OVER
      '{2'd3, 1'b0, 1'b0, 1'b0},  // ROT
      '{2'd2, 1'b0, 1'b0, 1'b0},  // ADD
      '{2'd2, 1'b0, 1'b0, 1'b0},  // SUB
      '{2'd0, 1'b0, 1'b0, 1'b1},  // RPUSH
      '{2'd0, 1'b1, 1'b0, 1'b0},  // RPOP
      '{2'd1, 1'b0, 1'b0, 1'b1},  // TOR
      '{2'd0, 1'b1, 1'b1, 1'b0},  // FROMR
      '{2'd0, 1'b0, 1'b0, 1'b0},
      '{2'd0, 1'b0, 1'b0, 1'b0},
      '{2'd0, 1'b0, 1'b0, 1'b0}
   };

   function automatic logic op_legal(input logic [3:0] op);
      return op <= OP_FROMR;
   endfunction

endpackage

// File: rtl/stack_lifo.sv
// Register-array LIFO: each cycle pops pop_n entries then pushes push_n words
// (wr[0] deepest); top[0..2] expose the top three entries, 0 when absent.
module stack_lifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [1:0]                    pop_n,
   input  logic [1:0]                    push_n,
   input  logic [2:0][WIDTH-1:0]         wr,
   output logic [$clog2(DEPTH+1)-1:0]    count,
   output logic [2:0][WIDTH-1:0]         top
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   int base;

   always_comb base = int'(count) - int'(pop_n);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count <= '0;
      else        count <= CW'(base + int'(push_n));
   end

   // Storage is not reset; occupancy alone defines what is valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++)
         if (i < int'(push_n) && base + i < DEPTH)
            mem[AW'(base + i)] <= wr[i];
   end

   always_comb begin
      top = '0;
      for (int k = 0; k < 3; k++)
         if (int'(count) > k) top[k] = mem[AW'(int'(count) - 1 - k)];
   end

endmodule

// File: rtl/stack_engine.sv
// Forth-style data/return stack engine: one command per cycle, POP/RPOP
// return a word through a valid/ready response register.
module stack_engine
   import stack_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DDEPTH = 16,
   parameter int RDEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [3:0]                   cmd_op,
   input  logic [WIDTH-1:0]             cmd_data,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [WIDTH-1:0]             rsp_data,
   output logic                         rsp_err,
   output logic [WIDTH-1:0]             tos,
   output logic [WIDTH-1:0]             nos,
   output logic [$clog2(DDEPTH+1)-1:0]  dcount,
   output logic [$clog2(RDEPTH+1)-1:0]  rcount,
   output logic                         err_ovf,
   output logic                         err_unf,
   output logic                         err_ill,
   input  logic                         err_clr
);

   localparam int DW = $clog2(DDEPTH+1);
   localparam int RW = $clog2(RDEPTH+1);

   logic [2:0][WIDTH-1:0] d_top, r_top, d_wr, r_wr;
   logic [1:0]            d_pop, d_push, r_pop, r_push;
   op_req_t               req;
   logic                  fire, legal, unf, ovf, ok, is_rsp;

   assign cmd_ready = !rsp_valid || rsp_ready;
   assign fire      = cmd_valid && cmd_ready;
   assign legal     = op_legal(cmd_op);
   assign req       = OP_REQ[cmd_op];
   assign is_rsp    = legal && (cmd_op == OP_POP || cmd_op == OP_RPOP);

   // Underflow is judged first; a faulting op never touches either stack.
   assign unf = fire && legal && ((int'(dcount) < int'(req.d_need)) || (req.r_need && rcount == '0));
   assign ovf = fire && legal && !unf &&
                ((req.d_grow && dcount == DW'(DDEPTH)) || (req.r_grow && rcount == RW'(RDEPTH)));
   assign ok  = fire && legal && !unf && !ovf;

   assign tos = d_top[0];
   assign nos = d_top[1];

   always_comb begin
      d_pop = 2'd0; d_push = 2'd0; d_wr = '0;
      r_pop = 2'd0; r_push = 2'd0; r_wr = '0;
      if (ok) begin
         case (cmd_op)
            OP_PUSH:  begin d_push = 2'd1; d_wr[0] = cmd_data; end
            OP_POP:   d_pop = 2'd1;
            OP_DUP:   begin d_push = 2'd1; d_wr[0] = d_top[0]; end
            OP_SWAP:  begin d_pop = 2'd2; d_push = 2'd2; d_wr[0] = d_top[0]; d_wr[1] = d_top[1]; end
            OP_OVER:  begin d_push = 2'd1; d_wr[0] = d_top[1]; end
            OP_ROT:   begin
               d_pop = 2'd3; d_push = 2'd3;
               d_wr[0] = d_top[1]; d_wr[1] = d_top[0]; d_wr[2] = d_top[2];
            end
            OP_ADD:   begin d_pop = 2'd2; d_push = 2'd1; d_wr[0] = d_top[1] + d_top[0]; end
            OP_SUB:   begin d_pop = 2'd2; d_push = 2'd1; d_wr[0] = d_top[1] - d_top[0]; end
            OP_RPUSH: begin r_push = 2'd1; r_wr[0] = cmd_data; end
            OP_RPOP:  r_pop = 2'd1;
            OP_TOR:   begin d_pop = 2'd1; r_push = 2'd1; r_wr[0] = d_top[0]; end
            OP_FROMR: begin r_pop = 2'd1; d_push = 2'd1; d_wr[0] = r_top[0]; end
            default:  ;
         endcase
      end
   end

   stack_lifo #(.WIDTH(WIDTH), .DEPTH(DDEPTH)) u_dstack (
      .clk(clk), .rst_n(rst_n), .pop_n(d_pop), .push_n(d_push), .wr(d_wr),
      .count(dcount), .top(d_top)
   );

   stack_lifo #(.WIDTH(WIDTH), .DEPTH(RDEPTH)) u_rstack (
      .clk(clk), .rst_n(rst_n), .pop_n(r_pop), .push_n(r_push), .wr(r_wr),
      .count(rcount), .top(r_top)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         err_ovf   <= 1'b0;
         err_unf   <= 1'b0;
         err_ill   <= 1'b0;
      end else begin
         if (fire && is_rsp) begin
            rsp_valid <= 1'b1;
            rsp_err   <= unf;
            rsp_data  <= unf ? '0 : ((cmd_op == OP_POP) ? d_top[0] : r_top[0]);
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
         // A fresh error wins over a simultaneous clear.
         err_ovf <= (err_ovf && !err_clr) || ovf;
         err_unf <= (err_unf && !err_clr) || unf;
         err_ill <= (err_ill && !err_clr) || (fire && !legal);
      end
   end

endmodule

// File: tb/tb_stack_engine.sv
// Self-checking bench for stack_engine: directed scenarios plus random ops
// checked against a queue-based model of the two stacks.
module tb_stack_engine;
   import stack_pkg::*;

   localparam int W  = 16;
   localparam int DD = 16;
   localparam int RD = 16;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          cmd_valid = 1'b0, rsp_ready = 1'b1, err_clr = 1'b0;
   logic [3:0]    cmd_op = 4'd0;
   logic [W-1:0]  cmd_data = '0;
   logic          cmd_ready, rsp_valid, rsp_err, err_ovf, err_unf, err_ill;
   logic [W-1:0]  rsp_data, tos, nos;
   logic [4:0]    dcount, rcount;

   stack_engine #(.WIDTH(W), .DDEPTH(DD), .RDEPTH(RD)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .tos(tos), .nos(nos),
      .dcount(dcount), .rcount(rcount), .err_ovf(err_ovf), .err_unf(err_unf),
      .err_ill(err_ill), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model
   logic [W-1:0] dq[$];
   logic [W-1:0] rq[$];
   logic         m_ovf = 1'b0, m_unf = 1'b0, m_ill = 1'b0;
   logic         m_rv = 1'b0, m_re = 1'b0;
   logic [W-1:0] m_rd = '0;

   function automatic logic [W-1:0] m_tos();
      return (dq.size() > 0) ? dq[dq.size()-1] : '0;
   endfunction

   function automatic logic [W-1:0] m_nos();
      return (dq.size() > 1) ? dq[dq.size()-2] : '0;
   endfunction

   task automatic model(input logic [3:0] op, input logic [W-1:0] d, input logic clr);
      logic u, o, il;
      logic [W-1:0] a, b, c;
      u = 1'b0; o = 1'b0; il = 1'b0;
      case (op)
         4'd1:  if (dq.size() == DD) o = 1'b1; else dq.push_back(d);
         4'd2:  if (dq.size() < 1) u = 1'b1; else m_rd = dq.pop_back();
         4'd3:  if (dq.size() < 1) u = 1'b1; else if (dq.size() == DD) o = 1'b1; else dq.push_back(m_tos());
         4'd4:  if (dq.size() < 2) u = 1'b1;
                else begin b = dq.pop_back(); a = dq.pop_back(); dq.push_back(b); dq.push_back(a); end
         4'd5:  if (dq.size() < 2) u = 1'b1; else if (dq.size() == DD) o = 1'b1; else dq.push_back(m_nos());
         4'd6:  if (dq.size() < 3) u = 1'b1;
                else begin
                   c = dq.pop_back(); b = dq.pop_back(); a = dq.pop_back();
                   dq.push_back(b); dq.push_back(c); dq.push_back(a);
                end
         4'd7:  if (dq.size() < 2) u = 1'b1;
                else begin b = dq.pop_back(); a = dq.pop_back(); dq.push_back(a + b); end
         4'd8:  if (dq.size() < 2) u = 1'b1;
                else begin b = dq.pop_back(); a = dq.pop_back(); dq.push_back(a - b); end
         4'd9:  if (rq.size() == RD) o = 1'b1; else rq.push_back(d);
         4'd10: if (rq.size() < 1) u = 1'b1; else m_rd = rq.pop_back();
         4'd11: if (dq.size() < 1) u = 1'b1; else if (rq.size() == RD) o = 1'b1; else rq.push_back(dq.pop_back());
         4'd12: if (rq.size() < 1) u = 1'b1; else if (dq.size() == DD) o = 1'b1; else dq.push_back(rq.pop_back());
         4'd13, 4'd14, 4'd15: il = 1'b1;
         default: ;
      endcase
      if (op == 4'd2 || op == 4'd10) begin
         m_rv = 1'b1; m_re = u;
         if (u) m_rd = '0;
      end else begin
         m_rv = 1'b0;
      end
      m_ovf = (m_ovf && !clr) || o;
      m_unf = (m_unf && !clr) || u;
      m_ill = (m_ill && !clr) || il;
   endtask

   task automatic model_reset();
      dq.delete(); rq.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_ill = 1'b0;
      m_rv = 1'b0; m_re = 1'b0; m_rd = '0;
   endtask

   // Offer one command for one cycle (rsp_ready as currently driven).
   task automatic send(input logic [3:0] op, input logic [W-1:0] d, input logic clr);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d; err_clr = clr;
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL send_ready op=%0d: got cmd_ready=%b want 1", op, cmd_ready);
      end
      @(posedge clk);
      model(op, d, clr);
      #1;
      cmd_valid = 1'b0; err_clr = 1'b0;
   endtask

   task automatic test_reset();
      logic [66:0] got, want;
      #3;
      got  = {dcount, rcount, rsp_valid, rsp_data, rsp_err, err_ovf, err_unf, err_ill, tos, nos, cmd_ready};
      want = {5'd0, 5'd0, 1'b0, 16'd0, 1'b0, 3'b000, 16'd0, 16'd0, 1'b1};
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL reset_state: got %h want %h", got, want); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_sub();
      send(OP_PUSH, 16'd5, 1'b0);
      send(OP_PUSH, 16'd3, 1'b0);
      send(OP_SUB, 16'd0, 1'b0);
      send(OP_POP, 16'd0, 1'b0);
      n_checks++;
      if ({rsp_valid, rsp_data, rsp_err, dcount} !== {1'b1, 16'd2, 1'b0, 5'd0}) begin
         n_fail++;
         $display("FAIL sub_pop: got v=%b d=%0d e=%b cnt=%0d want v=1 d=2 e=0 cnt=0",
                  rsp_valid, rsp_data, rsp_err, dcount);
      end
   endtask

   task automatic test_rot_add();
      send(OP_PUSH, 16'd1, 1'b0);
      send(OP_PUSH, 16'd2, 1'b0);
      send(OP_PUSH, 16'd3, 1'b0);
      send(OP_ROT, 16'd0, 1'b0);
      n_checks++;
      if ({tos, nos, dcount} !== {16'd1, 16'd3, 5'd3}) begin
         n_fail++; $display("FAIL rot: got tos=%0d nos=%0d cnt=%0d want 1 3 3", tos, nos, dcount);
      end
      send(OP_ADD, 16'd0, 1'b0);
      n_checks++;
      if ({tos, dcount} !== {16'd4, 5'd2}) begin
         n_fail++; $display("FAIL add: got tos=%0d cnt=%0d want 4 2", tos, dcount);
      end
      send(OP_POP, 16'd0, 1'b0);
      send(OP_POP, 16'd0, 1'b0);
   endtask

   task automatic test_overflow();
      for (int i = 0; i < DD; i++) send(OP_PUSH, W'(i + 10), 1'b0);
      n_checks++;
      if ({dcount, err_ovf, tos} !== {5'd16, 1'b0, 16'd25}) begin
         n_fail++; $display("FAIL full_depth: got cnt=%0d ovf=%b tos=%0d want 16 0 25", dcount, err_ovf, tos);
      end
      send(OP_PUSH, 16'd99, 1'b0);
      n_checks++;
      if ({dcount, err_ovf, tos} !== {5'd16, 1'b1, 16'd25}) begin
         n_fail++; $display("FAIL push_ovf: got cnt=%0d ovf=%b tos=%0d want 16 1 25", dcount, err_ovf, tos);
      end
      send(OP_NOP, 16'd0, 1'b1);
      send(OP_DUP, 16'd0, 1'b0);
      n_checks++;
      if ({dcount, err_ovf, tos, nos} !== {5'd16, 1'b1, 16'd25, 16'd24}) begin
         n_fail++; $display("FAIL dup_ovf: got cnt=%0d ovf=%b tos=%0d nos=%0d", dcount, err_ovf, tos, nos);
      end
      send(OP_NOP, 16'd0, 1'b1);
      for (int i = 0; i < RD; i++) send(OP_RPUSH, W'(i), 1'b0);
      send(OP_TOR, 16'd0, 1'b0);
      n_checks++;
      if ({rcount, dcount, err_ovf} !== {5'd16, 5'd16, 1'b1}) begin
         n_fail++; $display("FAIL tor_ovf: got rcnt=%0d dcnt=%0d ovf=%b want 16 16 1", rcount, dcount, err_ovf);
      end
      for (int i = 0; i < DD; i++) send(OP_POP, 16'd0, 1'b0);
      for (int i = 0; i < RD; i++) send(OP_RPOP, 16'd0, 1'b0);
      send(OP_NOP, 16'd0, 1'b1);
   endtask

   task automatic test_underflow();
      send(OP_POP, 16'd0, 1'b0);
      n_checks++;
      if ({rsp_valid, rsp_data, rsp_err, err_unf} !== {1'b1, 16'd0, 1'b1, 1'b1}) begin
         n_fail++; $display("FAIL pop_empty: got v=%b d=%0d e=%b unf=%b want 1 0 1 1",
                            rsp_valid, rsp_data, rsp_err, err_unf);
      end
      send(OP_NOP, 16'd0, 1'b1);
      n_checks++;
      if (err_unf !== 1'b0) begin n_fail++; $display("FAIL unf_clear: got %b want 0", err_unf); end
      send(OP_PUSH, 16'd77, 1'b0);
      send(OP_SWAP, 16'd0, 1'b0);
      n_checks++;
      if ({err_unf, dcount, tos} !== {1'b1, 5'd1, 16'd77}) begin
         n_fail++; $display("FAIL swap_unf: got unf=%b cnt=%0d tos=%0d want 1 1 77", err_unf, dcount, tos);
      end
      // clear together with a new illegal op: only the new flag survives
      send(4'd13, 16'd0, 1'b1);
      n_checks++;
      if ({err_ovf, err_unf, err_ill, rsp_valid, dcount} !== {1'b0, 1'b0, 1'b1, 1'b0, 5'd1}) begin
         n_fail++; $display("FAIL clr_vs_new: got ovf=%b unf=%b ill=%b v=%b cnt=%0d want 0 0 1 0 1",
                            err_ovf, err_unf, err_ill, rsp_valid, dcount);
      end
      send(OP_POP, 16'd0, 1'b1);
   endtask

   task automatic test_backpressure();
      send(OP_PUSH, 16'd55, 1'b0);
      rsp_ready = 1'b0;
      send(OP_POP, 16'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         cmd_valid = 1'b1; cmd_op = OP_PUSH; cmd_data = 16'd42;
         n_checks++;
         if ({cmd_ready, rsp_valid, rsp_data} !== {1'b0, 1'b1, 16'd55}) begin
            n_fail++; $display("FAIL stall_%0d: got rdy=%b v=%b d=%0d want 0 1 55", i, cmd_ready, rsp_valid, rsp_data);
         end
      end
      rsp_ready = 1'b1;
      #1;
      n_checks++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", cmd_ready); end
      @(posedge clk);
      model(OP_PUSH, 16'd42, 1'b0);
      #1 cmd_valid = 1'b0;
      n_checks++;
      if ({tos, dcount, rsp_valid} !== {16'd42, 5'd1, 1'b0}) begin
         n_fail++; $display("FAIL release_accept: got tos=%0d cnt=%0d v=%b want 42 1 0", tos, dcount, rsp_valid);
      end
      send(OP_POP, 16'd0, 1'b0);
   endtask

   task automatic test_return_and_reset();
      logic [66:0] got, want;
      send(OP_PUSH, 16'd7, 1'b0);
      send(OP_TOR, 16'd0, 1'b0);
      send(OP_RPUSH, 16'd9, 1'b0);
      send(OP_RPOP, 16'd0, 1'b0);
      n_checks++;
      if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, 16'd9, 1'b0}) begin
         n_fail++; $display("FAIL rpop: got v=%b d=%0d e=%b want 1 9 0", rsp_valid, rsp_data, rsp_err);
      end
      send(OP_FROMR, 16'd0, 1'b0);
      n_checks++;
      if ({tos, rcount, dcount} !== {16'd7, 5'd0, 5'd1}) begin
         n_fail++; $display("FAIL fromr: got tos=%0d rcnt=%0d dcnt=%0d want 7 0 1", tos, rcount, dcount);
      end
      // leave a response pending, then reset mid-sequence
      send(OP_TOR, 16'd0, 1'b0);
      send(4'd15, 16'd0, 1'b0);
      rsp_ready = 1'b0;
      send(OP_RPOP, 16'd0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      got  = {dcount, rcount, rsp_valid, rsp_data, rsp_err, err_ovf, err_unf, err_ill, tos, nos, cmd_ready};
      want = {5'd0, 5'd0, 1'b0, 16'd0, 1'b0, 3'b000, 16'd0, 16'd0, 1'b1};
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL mid_reset: got %h want %h", got, want); end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1; rsp_ready = 1'b1;
   endtask

   task automatic test_random();
      logic [3:0]   op;
      logic [W-1:0] d;
      logic         clr;
      int           r;
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom % 10);
         if (r < 3)       op = OP_PUSH;
         else if (r == 3) op = OP_RPUSH;
         else             op = 4'($urandom_range(0, 15));
         d   = W'($urandom);
         clr = ($urandom % 8) == 0;
         send(op, d, clr);
         n_checks++;
         if ({tos, nos} !== {m_tos(), m_nos()}) begin
            n_fail++; $display("FAIL rnd_top[%0d] op=%0d: got %h/%h want %h/%h", i, op, tos, nos, m_tos(), m_nos());
         end
         n_checks++;
         if ({int'(dcount), int'(rcount)} !== {dq.size(), rq.size()}) begin
            n_fail++; $display("FAIL rnd_count[%0d] op=%0d: got %0d/%0d want %0d/%0d",
                               i, op, dcount, rcount, dq.size(), rq.size());
         end
         n_checks++;
         if ({err_ovf, err_unf, err_ill} !== {m_ovf, m_unf, m_ill}) begin
            n_fail++; $display("FAIL rnd_flags[%0d] op=%0d: got %b%b%b want %b%b%b",
                               i, op, err_ovf, err_unf, err_ill, m_ovf, m_unf, m_ill);
         end
         n_checks++;
         if (rsp_valid !== m_rv || (m_rv && {rsp_data, rsp_err} !== {m_rd, m_re})) begin
            n_fail++; $display("FAIL rnd_rsp[%0d] op=%0d: got v=%b d=%h e=%b want v=%b d=%h e=%b",
                               i, op, rsp_valid, rsp_data, rsp_err, m_rv, m_rd, m_re);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_sub();
      test_rot_add();
      test_overflow();
      test_underflow();
      test_backpressure();
      test_return_and_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
